// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-byte holding register so consecutive frames
// leave the line with no idle gap. Bit timing comes from a divider on i_clk.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       hold_reg, hold_next;
    logic             hold_full_reg, hold_full_next;
    logic             tx_reg, tx_next;
    logic             accept;
    logic             bit_end;
    logic             stop_last;

    assign accept    = i_valid && !hold_full_reg;
    assign bit_end   = (cnt_reg == CNT_MAX);
    assign stop_last = (state_reg == STOP) && bit_end;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            tx_reg        <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            tx_reg        <= tx_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;

        case (state_reg)
            IDLE: begin
                cnt_next     = '0;
                bit_idx_next = '0;
                if (accept) begin
                    shift_next = i_data;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_next     = '0;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_next = '0;
                    // A byte offered in this very cycle bypasses the empty
                    // holding register and launches with zero gap.
                    if (hold_full_reg) begin
                        shift_next     = hold_reg;
                        hold_full_next = 1'b0;
                        state_next     = START;
                    end else if (accept) begin
                        shift_next = i_data;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        if (accept && (state_reg != IDLE) && !stop_last) begin
            hold_next      = i_data;
            hold_full_next = 1'b1;
        end
    end

    // Line level is derived from the upcoming state so o_tx stays registered
    // yet moves on the same edge as the state change.
    always_comb begin
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign o_ready = !hold_full_reg;
    assign o_tx    = tx_reg;
    assign o_busy  = (state_reg != IDLE);
    assign o_done  = stop_last;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: per-cycle comparison against a
// frame-timing reference model, a vector table and hand-built corner sequences.
module tb_uart_transmitter;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam int LOGN  = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       ready, tx, busy, done;

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_data  (data),
        .i_valid (valid),
        .o_ready (ready),
        .o_tx    (tx),
        .o_busy  (busy),
        .o_done  (done)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cycle;
    int done_q[$];

    logic tx_log    [0:LOGN-1];
    logic ready_log [0:LOGN-1];
    logic busy_log  [0:LOGN-1];
    logic done_log  [0:LOGN-1];

    // Reference model: the frame on the line is described by its start cycle
    // and byte; the holding register is a single optional byte.
    bit         m_active = 1'b0;
    int         m_start  = 0;
    logic [7:0] m_byte   = 8'h00;
    bit         m_hold_v = 1'b0;
    logic [7:0] m_hold   = 8'h00;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0b required=%0b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] model_out();
        int   pos;
        int   slot;
        logic etx, ebusy, edone;
        etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
        if (m_active) begin
            pos   = cyc - m_start;
            slot  = pos / CPB;
            ebusy = 1'b1;
            if (slot == 0)      etx = 1'b0;
            else if (slot <= 8) etx = m_byte[slot-1];
            edone = (pos == FRAME - 1);
        end
        return {etx, ebusy, edone, !m_hold_v};
    endfunction

    // One clock cycle: drive, sample mid-cycle, compare, advance model.
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        logic [3:0] e;
        bit         m_acc;
        int         pos;
        rst = r; valid = v; data = d;
        @(negedge clk);
        if (cyc < LOGN) begin
            tx_log[cyc] = tx; ready_log[cyc] = ready;
            busy_log[cyc] = busy; done_log[cyc] = done;
        end
        if (done === 1'b1) done_q.push_back(cyc);
        e = model_out();
        chk("tx", tx, e[3]);
        chk("busy", busy, e[2]);
        chk("done", done, e[1]);
        chk("ready", ready, e[0]);
        acc_cycle = (v && (ready === 1'b1) && !r) ? cyc : -1;
        if (acc_cycle >= 0) $display("accept cyc=%0d data=%02h", cyc, d);
        if (r) begin
            m_active = 1'b0;
            m_hold_v = 1'b0;
        end else begin
            m_acc = v && !m_hold_v;
            pos   = cyc - m_start;
            if (m_active && pos == FRAME - 1) begin
                if (m_hold_v) begin
                    m_start = cyc + 1; m_byte = m_hold; m_hold_v = 1'b0;
                end else if (m_acc) begin
                    m_start = cyc + 1; m_byte = d;
                end else begin
                    m_active = 1'b0;
                end
            end else if (m_active) begin
                if (m_acc) begin
                    m_hold_v = 1'b1; m_hold = d;
                end
            end else if (m_acc) begin
                m_active = 1'b1; m_start = cyc + 1; m_byte = d;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || ready !== 1'b1) && n < 200) begin
            step(1'b0, 1'b0, 8'h00);
            n++;
        end
        if (n >= 200) chk("wait_idle_timeout", busy, 1'b0);
    endtask

    task automatic chk_frame(input string name, input int t0, input logic [9:0] frame);
        for (int k = 0; k < 10; k++) chk(name, tx_log[t0 + k*CPB + 1], frame[k]);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       vecs[6];
        int         t;
        int         zeros;
        logic [7:0] pend[$];
        int         acc_t[$];

        vecs = '{'{8'hA5, 10'h34A}, '{8'h55, 10'h2AA}, '{8'h00, 10'h200},
                 '{8'hFF, 10'h3FE}, '{8'h3C, 10'h278}, '{8'h81, 10'h302}};

        rst = 1'b1; valid = 1'b0; data = 8'h00;
        @(posedge clk);
        #1;

        // Reset held with a byte offered: nothing may be accepted.
        repeat (3) step(1'b1, 1'b1, 8'hAA);
        step(1'b0, 1'b0, 8'h00);
        chk("rst_busy_after", busy_log[cyc-1], 1'b0);
        chk_int("rst_no_done", done_q.size(), 0);

        // Single-byte frames from the vector table.
        for (int i = 0; i < 6; i++) begin
            wait_idle();
            step(1'b0, 1'b1, vecs[i].data);
            chk_int("tbl_accept", acc_cycle, cyc - 1);
            t = cyc;
            idle(FRAME + 2);
            chk_frame("tbl_frame", t, vecs[i].frame);
            chk("tbl_done_last", done_log[t + FRAME - 1], 1'b1);
            chk("tbl_done_early", done_log[t + FRAME - 2], 1'b0);
            chk("tbl_busy_end", busy_log[t + FRAME], 1'b0);
        end

        // Back-to-back: second byte goes straight into the holding register.
        wait_idle();
        done_q.delete();
        step(1'b0, 1'b1, 8'h55);
        t = cyc;
        step(1'b0, 1'b1, 8'h0F);
        chk_int("b2b_hold_accept", acc_cycle, t);
        idle(2 * FRAME + 2);
        chk("b2b_ready_low", ready_log[t + 1], 1'b0);
        chk("b2b_ready_back", ready_log[t + FRAME], 1'b1);
        chk("b2b_stop_high", tx_log[t + FRAME - 1], 1'b1);
        chk("b2b_start2", tx_log[t + FRAME], 1'b0);
        chk_frame("b2b_frame2", t + FRAME, 10'h21E);
        chk_int("b2b_done_cnt", done_q.size(), 2);
        if (done_q.size() == 2) begin
            chk_int("b2b_done0", done_q[0], t + FRAME - 1);
            chk_int("b2b_done1", done_q[1], t + 2*FRAME - 1);
        end

        // Accept in the final stop cycle launches with zero gap.
        wait_idle();
        step(1'b0, 1'b1, 8'h00);
        t = cyc;
        while (cyc < t + FRAME - 1) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        chk_int("fin_accept_cycle", acc_cycle, t + FRAME - 1);
        idle(FRAME + 2);
        chk_frame("fin_frame", t + FRAME, 10'h3FE);

        // Backpressure: three bytes offered continuously.
        wait_idle();
        done_q.delete();
        pend = '{8'h11, 8'h22, 8'h33};
        for (int n = 0; n < 200 && pend.size() > 0; n++) begin
            step(1'b0, 1'b1, pend[0]);
            if (acc_cycle >= 0) begin
                acc_t.push_back(acc_cycle);
                void'(pend.pop_front());
            end
        end
        chk_int("bp_all_accepted", pend.size(), 0);
        idle(3 * FRAME + 2);
        if (acc_t.size() == 3) begin
            t = acc_t[0] + 1;
            chk_int("bp_third_accept", acc_t[2], t + FRAME);
            chk_frame("bp_frame1", t, 10'h222);
            chk_frame("bp_frame2", t + FRAME, 10'h244);
            chk_frame("bp_frame3", t + 2*FRAME, 10'h266);
            chk_int("bp_done_cnt", done_q.size(), 3);
            if (done_q.size() == 3) chk_int("bp_done2", done_q[2], t + 3*FRAME - 1);
        end

        // Reset in the middle of a frame.
        wait_idle();
        done_q.delete();
        step(1'b0, 1'b1, 8'h3C);
        t = cyc;
        while (cyc < t + 15) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        idle(FRAME + 5);
        zeros = 0;
        for (int c = t + 16; c < t + 16 + FRAME; c++) if (tx_log[c] !== 1'b1) zeros++;
        chk_int("mrst_line_high", zeros, 0);
        chk_int("mrst_no_done", done_q.size(), 0);
        step(1'b0, 1'b1, 8'h81);
        t = cyc;
        idle(FRAME + 2);
        chk_frame("mrst_after", t, 10'h302);

        // Randomised traffic with occasional reset.
        wait_idle();
        for (int n = 0; n < 800; n++) begin
            step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 2) != 0),
                 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
8N1 UART transmitter that serialises bytes onto a TX line idling high. Fills the stage directly upstream of the receiver: its o_tx drives the receiver's i_rx on board loopback and on the link to the host. Carries a one-byte holding register so back-to-back bytes go out with no idle gap between frames. Bit timing comes from an internal divider on i_clk; no separate baud clock domain.

Parameters:
CLKS_PER_BIT, 104, i_clk cycles per bit: 12 MHz / 115200 baud. Legal range 2..65535; the counter width is derived from it.

Ports:
i_clk  input  1  system clock; all logic on its rising edge
i_rst  input  1  synchronous active-high reset
i_data  input  8  byte to send; sampled only on an accept
i_valid  input  1  byte on i_data is offered
o_ready  output  1  block can accept a byte this cycle (holding register empty)
o_tx  output  1  serial line, registered; idle high
o_busy  output  1  a frame is on the line (state != IDLE)
o_done  output  1  one-cycle pulse in the final cycle of each stop bit

Behaviour:
- Reset:
  - i_rst high at an edge forces IDLE.
  - Outputs after that edge: o_tx=1, o_ready=1, o_busy=0, o_done=0.
  - Baud counter, bit index, shift register and holding register all clear.
  - Reset mid-frame aborts the frame. The line is high from the next cycle and no o_done pulse is generated.
- Accept:
  - An accept is i_valid && o_ready at a rising edge.
  - o_ready = ~hold_full, registered state only. It does not depend on i_valid.
- States are IDLE, START, DATA, STOP.
  - Baud counter counts 0..CLKS_PER_BIT-1 in each non-IDLE state.
  - Every bit, start and stop included, holds o_tx for exactly CLKS_PER_BIT cycles.
- IDLE:
  - o_tx=1.
  - On an accept, i_data loads straight into the shift register and the state moves to START. The holding register stays empty.
  - o_tx goes 0 on the same edge, so latency from the accept edge to the start bit on the line is zero cycles.
- START:
  - o_tx=0.
  - On counter wrap: move to DATA with bit index 0.
- DATA:
  - o_tx = shift[0]; data goes out LSB first.
  - On counter wrap: shift right one place and increment the bit index.
  - After bit index 7 wraps: move to STOP.
- STOP:
  - o_tx=1.
  - In the final cycle (counter = CLKS_PER_BIT-1): o_done=1.
  - On that edge, if hold_full: the holding byte moves to the shift register, hold_full clears, the state moves to START, and o_tx=0 on the next cycle. There is no idle bit between frames.
  - Otherwise: move to IDLE.
- Holding register:
  - An accept while state != IDLE writes the holding register and sets hold_full.
  - An accept in the final STOP cycle while the holding register is empty is legal. The byte is held and then launched on that same edge, with zero gap. This is equivalent to hold being loaded and drained on the same edge.
  - hold_full set and cleared on the same edge cannot occur, because o_ready=0 whenever hold_full=1.
- i_valid while o_ready=0 is ignored. The byte is not captured and the offering side must hold it.
- i_data is a don't-care when there is no accept.
- Frame length is 10*CLKS_PER_BIT cycles. Sustained throughput is one byte per 10*CLKS_PER_BIT cycles.
- No parity, one stop bit, no break generation.

Test Plan:
(All cases use CLKS_PER_BIT=4, so one frame is 40 cycles.)
- Reset: hold i_rst 3 cycles with i_valid=1 -> o_tx=1, o_ready=1, o_busy=0, o_done=0 throughout; no accept.
- Single byte 0xA5, accepted in IDLE at edge T:
  - o_tx at 4-cycle granularity from T is 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop).
  - o_done is high only in cycle T+39.
  - o_busy falls at T+40.
- Back-to-back: 0x55 accepted at T, then 0x0F offered from T+1 and accepted at T+1 (o_ready drops after T+1):
  - Second start bit begins at T+40 with no high gap.
  - o_ready returns to 1 at T+40.
  - Two o_done pulses, at T+39 and T+79.
- Final-cycle accept: 0x00 at T, then 0xFF accepted exactly at T+39 -> start bit of 0xFF at T+40; line reads 0xFF LSB-first.
- Backpressure: three bytes offered continuously -> the third is accepted only when o_ready rises at T+40; the line carries all three in order, contiguously.
- Mid-frame reset: i_rst asserted at T+15 during 0x3C -> o_tx=1 from T+16; no o_done; a new byte 0x81 accepted after reset transmits correctly.
